// File: rtl/exec_decode_unit.sv
// RV32I decode/execute slice: decode, operand select, ALU, one register stage.
// Optional EXEC_TRACE_EN prints a per-cycle execution trace in simulation.
module exec_decode_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     cmd,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] imm,
   output logic [2:0]      op_imm,
   output logic [XLEN-1:0] result,
   output logic            is_zero,
   output logic            en_wreg,
   output logic            en_wmem,
   output logic            branch,
   output logic            load
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_SLL   = 4'b0001;
   localparam logic [3:0] ALU_SLT   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SRL   = 4'b0101;
   localparam logic [3:0] ALU_SRA   = 4'b1101;
   localparam logic [3:0] ALU_OR    = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b0111;
   localparam logic [3:0] ALU_COPYB = 4'b1111;

   localparam logic [2:0] IMM_I    = 3'b000;
   localparam logic [2:0] IMM_S    = 3'b001;
   localparam logic [2:0] IMM_B    = 3'b010;
   localparam logic [2:0] IMM_U    = 3'b011;
   localparam logic [2:0] IMM_J    = 3'b100;
   localparam logic [2:0] IMM_NONE = 3'b111;

   localparam logic       ASRC_RS1 = 1'b0;
   localparam logic       ASRC_PC  = 1'b1;
   localparam logic [1:0] BSRC_RS2 = 2'b00;
   localparam logic [1:0] BSRC_IMM = 2'b01;
   localparam logic [1:0] BSRC_4   = 2'b10;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            f7;

   logic            asrc;
   logic [1:0]      bsrc;
   logic [3:0]      sel;
   logic            dec_wreg;
   logic            dec_wmem;
   logic            dec_branch;
   logic            dec_load;

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_res;

   logic            unused_cmd;

   assign opcode = cmd[6:0];
   assign funct3 = cmd[14:12];
   assign f7     = cmd[30];

   assign unused_cmd = ^{cmd[31], cmd[29:15], cmd[11:7]};

   // Control decode
   always_comb begin
      asrc       = ASRC_RS1;
      bsrc       = BSRC_RS2;
      sel        = ALU_ADD;
      op_imm     = IMM_NONE;
      dec_wreg   = 1'b0;
      dec_wmem   = 1'b0;
      dec_branch = 1'b0;
      dec_load   = 1'b0;
      case (opcode)
         OPC_OP: begin
            sel      = {f7, funct3};
            dec_wreg = 1'b1;
         end
         OPC_OP_IMM: begin
            bsrc     = BSRC_IMM;
            // bit 30 is immediate data except on the shift-right encodings
            sel      = {(funct3 == 3'b101) & f7, funct3};
            op_imm   = IMM_I;
            dec_wreg = 1'b1;
         end
         OPC_LUI: begin
            bsrc     = BSRC_IMM;
            sel      = ALU_COPYB;
            op_imm   = IMM_U;
            dec_wreg = 1'b1;
         end
         OPC_AUIPC: begin
            asrc     = ASRC_PC;
            bsrc     = BSRC_IMM;
            op_imm   = IMM_U;
            dec_wreg = 1'b1;
         end
         OPC_JAL: begin
            asrc     = ASRC_PC;
            bsrc     = BSRC_4;
            op_imm   = IMM_J;
            dec_wreg = 1'b1;
         end
         OPC_JALR: begin
            asrc     = ASRC_PC;
            bsrc     = BSRC_4;
            op_imm   = IMM_I;
            dec_wreg = 1'b1;
         end
         OPC_LOAD: begin
            bsrc     = BSRC_IMM;
            op_imm   = IMM_I;
            dec_wreg = 1'b1;
            dec_load = 1'b1;
         end
         OPC_STORE: begin
            bsrc     = BSRC_IMM;
            op_imm   = IMM_S;
            dec_wmem = 1'b1;
         end
         OPC_BRANCH: begin
            op_imm     = IMM_B;
            dec_branch = 1'b1;
            case (funct3[2:1])
               2'b00:   sel = ALU_SUB;
               2'b10:   sel = ALU_SLT;
               2'b11:   sel = ALU_SLTU;
               default: sel = ALU_ADD;
            endcase
         end
         default: ;
      endcase
   end

   // Operand muxes
   always_comb begin
      a = src1;
      if (asrc == ASRC_PC)
         a = pc;
   end

   always_comb begin
      b = src2;
      case (bsrc)
         BSRC_IMM: b = imm;
         BSRC_4:   b = XLEN'(4);
         default:  b = src2;
      endcase
   end

   assign shamt = b[4:0];

   // ALU
   always_comb begin
      alu_res = a + b;
      case (sel)
         ALU_SUB:   alu_res = a - b;
         ALU_SLL:   alu_res = a << shamt;
         ALU_SLT:   alu_res = XLEN'($signed(a) < $signed(b));
         ALU_SLTU:  alu_res = XLEN'(a < b);
         ALU_XOR:   alu_res = a ^ b;
         ALU_SRL:   alu_res = a >> shamt;
         ALU_SRA:   alu_res = XLEN'($signed(a) >>> shamt);
         ALU_OR:    alu_res = a | b;
         ALU_AND:   alu_res = a & b;
         ALU_COPYB: alu_res = b;
         default:   alu_res = a + b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result  <= '0;
         is_zero <= 1'b1;
         en_wreg <= 1'b0;
         en_wmem <= 1'b0;
         branch  <= 1'b0;
         load    <= 1'b0;
      end else begin
         result  <= alu_res;
         is_zero <= (alu_res == '0);
         en_wreg <= dec_wreg;
         en_wmem <= dec_wmem;
         branch  <= dec_branch;
         load    <= dec_load;
      end
   end

`ifdef EXEC_TRACE_EN
   always @(posedge clk) begin
      if (!rst)
         $display("trace pc=%h asrc=%0d bsrc=%0d sel=%h op_imm=%0d a=%h b=%h res=%h",
                  pc, asrc, bsrc, sel, op_imm, a, b, alu_res);
   end
`else
`endif

endmodule

// File: tb/tb_exec_decode_unit.sv
// Directed scoreboard bench for exec_decode_unit.
module tb_exec_decode_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cmd, pc, src1, src2, imm;
   logic [2:0]  op_imm;
   logic [31:0] result;
   logic        is_zero, en_wreg, en_wmem, branch, load;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        iz;
      logic        wr;
      logic        wm;
      logic        br;
      logic        ld;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   exec_decode_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (cmd),
      .pc      (pc),
      .src1    (src1),
      .src2    (src2),
      .imm     (imm),
      .op_imm  (op_imm),
      .result  (result),
      .is_zero (is_zero),
      .en_wreg (en_wreg),
      .en_wmem (en_wmem),
      .branch  (branch),
      .load    (load)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r,
                       input logic [31:0] c, input logic [31:0] p,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] im, input logic [2:0] e_op,
                       input logic [31:0] e_res, input logic e_wr,
                       input logic e_wm, input logic e_br,
                       input logic e_ld);
      exp_t e, got;
      @(negedge clk);
      rst = r; cmd = c; pc = p;
      src1 = s1; src2 = s2; imm = im;
      #1;
      chk({tag, ".op_imm"}, 32'(op_imm), 32'(e_op));
      e.tag = tag;
      e.res = r ? 32'h0 : e_res;
      e.iz  = r ? 1'b1 : (e_res == 32'h0);
      e.wr  = r ? 1'b0 : e_wr;
      e.wm  = r ? 1'b0 : e_wm;
      e.br  = r ? 1'b0 : e_br;
      e.ld  = r ? 1'b0 : e_ld;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, result);
      end else begin
         got = q.pop_front();
         chk({got.tag, ".result"},  result,         got.res);
         chk({got.tag, ".is_zero"}, 32'(is_zero),   32'(got.iz));
         chk({got.tag, ".en_wreg"}, 32'(en_wreg),   32'(got.wr));
         chk({got.tag, ".en_wmem"}, 32'(en_wmem),   32'(got.wm));
         chk({got.tag, ".branch"},  32'(branch),    32'(got.br));
         chk({got.tag, ".load"},    32'(load),      32'(got.ld));
      end
   endtask

   initial begin
      rst = 1'b1; cmd = '0; pc = '0;
      src1 = '0; src2 = '0; imm = '0;

      // tag, rst, cmd, pc, src1, src2, imm, op_imm, res, wr, wm, br, ld
      step("reset",  1, 32'h0000_0000, 0, 0, 0, 0,
           3'b111, 32'h0, 0, 0, 0, 0);
      step("addi",   0, 32'h0050_0093, 0, 0, 0, 5,
           3'b000, 32'h5, 1, 0, 0, 0);
      step("sub",    0, 32'h4020_8033, 0, 10, 10, 0,
           3'b111, 32'h0, 1, 0, 0, 0);
      step("auipc",  0, 32'h0000_1097, 32'h8000_0000, 0, 0, 32'h1000,
           3'b011, 32'h8000_1000, 1, 0, 0, 0);
      step("jal",    0, 32'h0000_006F, 32'h8000_0004, 7, 9, 32'h55,
           3'b100, 32'h8000_0008, 1, 0, 0, 0);
      step("srai",   0, 32'h4040_D093, 0, 32'hF000_0000, 0, 32'h404,
           3'b000, 32'hFF00_0000, 1, 0, 0, 0);
      step("srli",   0, 32'h0040_D093, 0, 32'hF000_0000, 0, 32'h004,
           3'b000, 32'h0F00_0000, 1, 0, 0, 0);
      step("rst_mid", 1, 32'h0050_0093, 0, 0, 0, 5,
           3'b000, 32'h0, 0, 0, 0, 0);
      step("beq",    0, 32'h0020_8063, 0, 32'h1234, 32'h1234, 0,
           3'b010, 32'h0, 0, 0, 1, 0);
      step("bltu",   0, 32'h0020_E063, 0, 32'hFFFF_FFFF, 1, 0,
           3'b010, 32'h0, 0, 0, 1, 0);
      step("blt",    0, 32'h0020_C063, 0, 32'hFFFF_FFFF, 1, 0,
           3'b010, 32'h1, 0, 0, 1, 0);
      step("lw",     0, 32'h0000_A083, 0, 32'h100, 0, 8,
           3'b000, 32'h108, 1, 0, 0, 1);
      step("sw",     0, 32'h0020_A023, 0, 32'h200, 5, 32'hFFFF_FFFC,
           3'b001, 32'h1FC, 0, 1, 0, 0);
      step("lui",    0, 32'h1234_50B7, 0, 32'hDEAD, 0, 32'h1234_5000,
           3'b011, 32'h1234_5000, 1, 0, 0, 0);
      step("jalr",   0, 32'h0000_80E7, 32'h100, 32'h999, 0, 32'h10,
           3'b000, 32'h104, 1, 0, 0, 0);
      step("unknown", 0, 32'h0000_0000, 0, 7, 8, 32'h40,
           3'b111, 32'hF, 0, 0, 0, 0);
      step("or",     0, 32'h0020_E0B3, 0, 32'hF0F0, 32'h0F00, 0,
           3'b111, 32'hFFF0, 1, 0, 0, 0);
      step("sll",    0, 32'h0020_90B3, 0, 1, 32'h21, 0,
           3'b111, 32'h2, 1, 0, 0, 0);
      step("sra",    0, 32'h4020_D0B3, 0, 32'h8000_0000, 31, 0,
           3'b111, 32'hFFFF_FFFF, 1, 0, 0, 0);
      step("xori_b30", 0, 32'h4000_C093, 0, 32'hFF, 0, 32'h400,
           3'b000, 32'h4FF, 1, 0, 0, 0);
      step("and",    0, 32'h0020_F0B3, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0,
           3'b111, 32'h0F00_0F00, 1, 0, 0, 0);
      step("sltu",   0, 32'h0020_B0B3, 0, 1, 2, 0,
           3'b111, 32'h1, 1, 0, 0, 0);
      step("slt_pos", 0, 32'h0020_A0B3, 0, 5, 32'hFFFF_FFFE, 0,
           3'b111, 32'h0, 1, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_decode_unit.md
Name: exec_decode_unit

Overview:
- Single-issue RV32I decode/execute slice: decodes one 32-bit instruction, selects ALU operands, computes the ALU result.
- Sits between register file/immediate decoder (upstream) and writeback (downstream).
- Combinational decode feeds an operand mux and ALU; the result and control flags are registered once.

Parameters:
- XLEN, 32, datapath width of operands and result (only 32 supported).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cmd  input  32  instruction word.
- pc  input  XLEN  PC of cmd.
- src1  input  XLEN  rs1 value.
- src2  input  XLEN  rs2 value.
- imm  input  XLEN  decoded immediate (from external decoder).
- op_imm  output  3  immediate format, combinational: 000 I, 001 S, 010 B, 011 U, 100 J, 111 none.
- result  output  XLEN  registered ALU result.
- is_zero  output  1  registered, result==0.
- en_wreg  output  1  registered register-write enable.
- en_wmem  output  1  registered store enable.
- branch  output  1  registered conditional-branch flag.
- load  output  1  registered load flag.

Behaviour:
- Decode uses opcode=cmd[6:0], funct3=cmd[14:12], f7=cmd[30].
- Control fields per opcode (asrc, bsrc, sel, op_imm, flags):
  - 0110011 OP: src1, src2, {f7,funct3}, 111, en_wreg.
  - 0010011 OP-IMM: src1, imm, {f7 only when funct3==101 else 0, funct3}, 000, en_wreg.
  - 0110111 LUI: src1, imm, COPYB, 011, en_wreg.
  - 0010111 AUIPC: pc, imm, ADD, 011, en_wreg.
  - 1101111 JAL: pc, 4, ADD, 100, en_wreg.
  - 1100111 JALR: pc, 4, ADD, 000, en_wreg.
  - 0000011 LOAD: src1, imm, ADD, 000, en_wreg + load.
  - 0100011 STORE: src1, imm, ADD, 001, en_wmem.
  - 1100011 BRANCH: src1, src2, 010, branch. funct3 00x → SUB, 10x → SLT, 11x → SLTU.
  - Any other opcode: all flags 0, op_imm 111, sel ADD, asrc src1, bsrc src2.
- Operand A mux (1-bit select): 0 → src1, 1 → pc.
- Operand B mux (2-bit select): 00 → src2, 01 → imm, 10 → constant 4, 11 → src2 (default).
- ALU sel encoding (4-bit):
  - 0000 ADD; 1000 SUB; 0001 SLL; 0010 SLT (signed); 0011 SLTU.
  - 0100 XOR; 0101 SRL; 1101 SRA; 0110 OR; 0111 AND; 1111 COPYB (result=b).
  - Unlisted codes → ADD.
- Arithmetic is modulo 2^32, with no overflow flag.
- Shifts use b[4:0] only.
- SLT/SLTU produce 0 or 1, zero-extended.
- Timing: all registered outputs update on the rising clk edge, 1-cycle latency from cmd/operands. op_imm is purely combinational, with 0-cycle latency.
- Reset: rst high at an edge forces result=0, is_zero=1, en_wreg=en_wmem=branch=load=0, regardless of cmd.
- Reset mid-stream: the instruction presented that cycle is discarded; normal operation resumes on the first edge with rst low.
- No handshake: a new instruction is accepted every cycle.
- Reserved: cmd=0 decodes as unknown, so all flags 0.

Optional Feature:
- Macro EXEC_TRACE_EN.
- Defined: at each rising edge with rst low, simulation prints pc, asrc, bsrc, sel, op_imm, a, b, and the ALU result (hex). Non-synthesizable code is confined to this block.
- Undefined: no print statements; functionally identical.

Test Plan:
- addi x1,x0,5: cmd=0x00500093, src1=0, imm=5 → op_imm=000 immediately; next edge result=5, en_wreg=1, is_zero=0.
- sub: cmd=0x40208033, src1=src2=10 → result=0, is_zero=1, en_wreg=1, op_imm=111.
- auipc: cmd=0x00001097, pc=0x80000000, imm=0x1000 → result=0x80001000, op_imm=011.
- jal: cmd=0x0000006F, pc=0x80000004 → result=0x80000008, en_wreg=1, op_imm=100.
- srai: cmd=0x4040D093, src1=0xF0000000, imm=0x404 → result=0xFF000000. Same case with f7 cleared (srli, cmd=0x0040D093, imm=0x004) → 0x0F000000.
- Reset/boundaries:
  - rst=1 with the addi stimulus → after edge result=0, is_zero=1, all flags 0.
  - beq with src1=src2 → branch=1, is_zero=1.
  - bltu with src1=0xFFFFFFFF, src2=1 → result=0.
